ledbanner_monitor: RTL
======================

LEDBANNER_MONITOR -- requirements
Module: ledbanner_monitor

Interface
REQ-001 SHALL have parameter LOCK_STEPS, default 2: consecutive correct rotation steps required before lock (legal range 1..7).
REQ-002 SHALL have parameter DIR_LEFT, default 1: 1 = expected next index is prev+1 mod 8; 0 = prev-1 mod 8.
REQ-003 SHALL have port clk6Hz, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port led_in, input, 8 bits: banner LED bus, sampled once per clk6Hz edge.
REQ-006 SHALL have port clear, input, 1 bit: synchronous restart of tracking and counters.
REQ-007 SHALL have port pos, output, 3 bits: index of the lit LED in the last one-hot sample.
REQ-008 SHALL have port pos_valid, output, 1 bit: high in ACQUIRE or LOCKED.
REQ-009 SHALL have port locked, output, 1 bit: high in LOCKED.
REQ-010 SHALL have port err_pulse, output, 1 bit: one-cycle pulse on a rotation fault.
REQ-011 SHALL have port err_count, output, 8 bits: fault count, saturating.
REQ-012 SHALL have port lap_pulse, output, 1 bit: one-cycle pulse on wrap while locked.
REQ-013 SHALL have port lap_count, output, 8 bits: completed laps, wrapping.

Function
REQ-014 SHALL classify each sample: ZERO (8'h00), ONEHOT (exactly one bit set, index idx), BAD (anything else).
REQ-015 SHALL register all outputs; a sample taken at edge N is reflected in the outputs immediately after edge N.
REQ-016 SHALL implement states IDLE, ACQUIRE, LOCKED, FAULT; good_cnt SHALL be 3 bits.
REQ-017 In IDLE, ONEHOT SHALL go to ACQUIRE with pos=idx and good_cnt=0; ZERO or BAD SHALL stay in IDLE.
REQ-018 In ACQUIRE, ONEHOT with idx==expected SHALL increment good_cnt, go to LOCKED when good_cnt+1==LOCK_STEPS, and set pos=idx.
REQ-019 In ACQUIRE, ONEHOT with idx!=expected SHALL set good_cnt=0 and pos=idx and stay in ACQUIRE; ZERO or BAD SHALL go to IDLE; no error SHALL be raised.
REQ-020 In LOCKED, ONEHOT with idx==expected SHALL update pos and stay in LOCKED.
REQ-021 In LOCKED, lap_pulse SHALL fire and lap_count SHALL increment (255->0) when pos wraps (7->0 for DIR_LEFT=1, 0->7 for DIR_LEFT=0).
REQ-022 In LOCKED, ZERO SHALL go to IDLE with no error; this is a generator reset, not a fault.
REQ-023 In LOCKED, BAD or unexpected ONEHOT SHALL go to FAULT, pulse err_pulse, and increment err_count, saturating at 255.
REQ-024 FAULT SHALL last exactly one cycle, then go to ACQUIRE (pos=idx, good_cnt=0) on ONEHOT, else to IDLE.
REQ-025 clear=1 SHALL force IDLE, zero both counters, drop pulses, and ignore that cycle's sample; rst_n SHALL take priority over clear.

Reset
REQ-026 rst_n=0 at a clock edge SHALL set state=IDLE, pos=0, pos_valid=0, locked=0, err_pulse=0, err_count=0, lap_pulse=0, lap_count=0, good_cnt=0.
REQ-027 Reset asserted mid-LOCKED SHALL abandon tracking with no err_pulse; the first ONEHOT after release SHALL enter ACQUIRE.

Configuration
REQ-028 Macro LEDBANNER_MON_LAPCNT_EN defined: lap_pulse and lap_count SHALL operate per REQ-021.
REQ-029 Macro LEDBANNER_MON_LAPCNT_EN undefined: lap_pulse and lap_count SHALL be constant 0 and the lap logic SHALL be absent; all else unchanged.

Structure
REQ-030 Shared package ledbanner_pkg SHALL hold LED_W=8, POS_W=3, and the monitor state encoding.
REQ-031 Sub-module onehot_enc8 (combinational: ZERO/ONEHOT/BAD flags plus 3-bit index) SHALL be instantiated once.

Verification
REQ-032 Reset, then led_in 01,02,04,08 on consecutive edges -> pos_valid after edge 1, locked after edge 3 (LOCK_STEPS=2), pos=3.
REQ-033 Locked stream ...40,80,01 -> one lap_pulse on the 01 edge, lap_count=1; with macro undefined, lap_count stays 0.
REQ-034 Locked at pos=2, inject 8'h10 -> FAULT, err_pulse for 1 cycle, err_count=1; next sample 20 -> ACQUIRE with pos=5.
REQ-035 Locked, inject 8'h00 -> IDLE, err_pulse=0, err_count unchanged; inject 8'h03 in IDLE -> stays IDLE.
REQ-036 Force 256 faults -> err_count saturates at 255; then clear=1 -> err_count=0, lap_count=0, state IDLE.
REQ-037 rst_n=0 and clear=1 on the same edge mid-LOCKED -> all REQ-026 values, no err_pulse.

Source files
------------

// File: rtl/ledbanner_pkg.sv
// ledbanner_pkg
// Shared widths, state encoding and helpers for the LED banner rotation
// monitor.
//   LED_W       : width of the banner LED bus
//   POS_W       : width of a LED index
//   mon_state_t : monitor FSM state encoding
//   step_pos()  : neighbour of a position in the rotation direction
package ledbanner_pkg;

  localparam int LED_W = 8;
  localparam int POS_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_FAULT   = 2'd3
  } mon_state_t;

  // Index arithmetic wraps naturally at POS_W bits (7+1 -> 0, 0-1 -> 7).
  function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] p,
                                                input bit dir_left);
    if (dir_left) begin
      return p + POS_W'(1);
    end
    return p - POS_W'(1);
  endfunction

endpackage

// File: rtl/ledbanner_onehot_enc8.sv
// onehot_enc8
// Combinational classifier for one 8-bit banner sample.
// Ports:
//   led       in  [7:0] sample to classify
//   is_zero   out       sample is all zeros
//   is_onehot out       exactly one bit set
//   is_bad    out       two or more bits set
//   idx       out [2:0] index of the set bit (meaningful only when is_onehot)
module onehot_enc8
  import ledbanner_pkg::*;
(
  input  logic [LED_W-1:0] led,
  output logic             is_zero,
  output logic             is_onehot,
  output logic             is_bad,
  output logic [POS_W-1:0] idx
);

  logic [3:0] ones;

  always_comb begin
    ones = 4'd0;
    idx  = '0;
    for (int i = 0; i < LED_W; i++) begin
      if (led[i]) begin
        ones = ones + 4'd1;
        idx  = POS_W'(i);
      end
    end
  end

  assign is_zero   = (ones == 4'd0);
  assign is_onehot = (ones == 4'd1);
  assign is_bad    = (ones > 4'd1);

endmodule

// File: rtl/ledbanner_monitor.sv
// ledbanner_monitor
// Tracks a single lit LED rotating around an 8-LED banner, declares lock
// after LOCK_STEPS consecutive correct steps, and reports rotation faults
// and (optionally) completed laps. All outputs are registered.
//
// Build option: define LEDBANNER_MON_LAPCNT_EN to include the lap counter;
// otherwise lap_pulse and lap_count are tied to 0 and no lap logic exists.
//
// Parameters:
//   LOCK_STEPS  1..7, consecutive correct steps needed to lock
//   DIR_LEFT    1: next index is prev+1 mod 8, 0: prev-1 mod 8
// Ports:
//   clk6Hz      in        clock, rising edge
//   rst_n       in        synchronous active-low reset (wins over clear)
//   led_in      in  [7:0] banner LED bus
//   clear       in        synchronous restart of tracking and counters
//   pos         out [2:0] index of the lit LED in the last one-hot sample
//   pos_valid   out       ACQUIRE or LOCKED
//   locked      out       LOCKED
//   err_pulse   out       one-cycle pulse on a rotation fault
//   err_count   out [7:0] saturating fault count
//   lap_pulse   out       one-cycle pulse on wrap while locked
//   lap_count   out [7:0] wrapping lap count
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | no rotation being tracked
// ACQUIRE  | following the LED, counting consecutive correct steps
// LOCKED   | rotation confirmed; deviations are faults
// FAULT    | one-cycle fault marker, then re-acquire or idle
module ledbanner_monitor
  import ledbanner_pkg::*;
#(
  parameter int LOCK_STEPS = 2,
  parameter int DIR_LEFT   = 1
) (
  input  logic             clk6Hz,
  input  logic             rst_n,
  input  logic [LED_W-1:0] led_in,
  input  logic             clear,
  output logic [POS_W-1:0] pos,
  output logic             pos_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic [7:0]       err_count,
  output logic             lap_pulse,
  output logic [7:0]       lap_count
);

  localparam bit         DIR_L    = (DIR_LEFT != 0);
  localparam logic [2:0] LOCK_TGT = 3'(LOCK_STEPS);

  mon_state_t       state_q, state_d;
  logic [2:0]       good_q, good_d;
  logic [POS_W-1:0] pos_d;
  logic             pos_valid_d, locked_d, err_pulse_d;
  logic [7:0]       err_count_d;

  logic             s_zero, s_onehot, s_bad;
  logic [POS_W-1:0] s_idx;
  logic [POS_W-1:0] expected;
  logic             match;

  onehot_enc8 u_enc (
    .led       (led_in),
    .is_zero   (s_zero),
    .is_onehot (s_onehot),
    .is_bad    (s_bad),
    .idx       (s_idx)
  );

  assign expected = step_pos(pos, DIR_L);
  assign match    = s_onehot && (s_idx == expected);

  always_ff @(posedge clk6Hz) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      good_q    <= 3'd0;
      pos       <= '0;
      pos_valid <= 1'b0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= 8'd0;
    end else begin
      state_q   <= state_d;
      good_q    <= good_d;
      pos       <= pos_d;
      pos_valid <= pos_valid_d;
      locked    <= locked_d;
      err_pulse <= err_pulse_d;
      err_count <= err_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    good_d      = good_q;
    pos_d       = pos;
    err_pulse_d = 1'b0;
    err_count_d = err_count;

    if (clear) begin
      // The sample on a clear cycle is discarded; pos keeps its old value.
      state_d     = ST_IDLE;
      good_d      = 3'd0;
      err_count_d = 8'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (s_onehot) begin
            state_d = ST_ACQUIRE;
            pos_d   = s_idx;
            good_d  = 3'd0;
          end
        end
        ST_ACQUIRE: begin
          if (s_onehot) begin
            pos_d = s_idx;
            if (match) begin
              good_d = good_q + 3'd1;
              if (good_q + 3'd1 == LOCK_TGT) begin
                state_d = ST_LOCKED;
              end
            end else begin
              good_d = 3'd0;
            end
          end else begin
            state_d = ST_IDLE;
            good_d  = 3'd0;
          end
        end
        ST_LOCKED: begin
          if (s_bad || (s_onehot && !match)) begin
            state_d     = ST_FAULT;
            good_d      = 3'd0;
            err_pulse_d = 1'b1;
            if (err_count != 8'hFF) begin
              err_count_d = err_count + 8'd1;
            end
            if (s_onehot) begin
              pos_d = s_idx;
            end
          end else if (s_zero) begin
            // All-dark means the generator restarted, not a fault.
            state_d = ST_IDLE;
            good_d  = 3'd0;
          end else begin
            pos_d = s_idx;
          end
        end
        ST_FAULT: begin
          good_d = 3'd0;
          if (s_onehot) begin
            state_d = ST_ACQUIRE;
            pos_d   = s_idx;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          good_d  = 3'd0;
        end
      endcase
    end

    pos_valid_d = (state_d == ST_ACQUIRE) || (state_d == ST_LOCKED);
    locked_d    = (state_d == ST_LOCKED);
  end

`ifdef LEDBANNER_MON_LAPCNT_EN
  // A correct step out of the last position in the rotation direction is a wrap.
  localparam logic [POS_W-1:0] WRAP_FROM = DIR_L ? POS_W'(7) : POS_W'(0);

  logic lap_hit;

  assign lap_hit = !clear && (state_q == ST_LOCKED) && match && (pos == WRAP_FROM);

  always_ff @(posedge clk6Hz) begin
    if (!rst_n) begin
      lap_pulse <= 1'b0;
      lap_count <= 8'd0;
    end else if (clear) begin
      lap_pulse <= 1'b0;
      lap_count <= 8'd0;
    end else begin
      lap_pulse <= lap_hit;
      if (lap_hit) begin
        lap_count <= lap_count + 8'd1;
      end
    end
  end
`else
  assign lap_pulse = 1'b0;
  assign lap_count = 8'd0;
`endif

endmodule
